// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider with RISC-V DIV/REM semantics.
// Fast paths for zero divisor, signed overflow and small dividends; kill flushes any operation.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic             error_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned SW = 2 * WIDTH - 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        DIVIDE,
        FIXUP,
        DONE,
        DONE_ERR
    } state_t;

    state_t           state_q;
    logic             ready_q, valid_q, error_q;
    logic             neg_q_q, neg_r_q;
    logic [WIDTH-1:0] quot_q, remo_q;
    logic [WIDTH-1:0] rem_q, q_q, bit_q;
    logic [SW-1:0]    sd_q;

    logic             dvd_neg_c, dvs_neg_c, ovf_c, ge_c;
    logic [WIDTH-1:0] dvd_mag_c, dvs_mag_c, rem_sub_c;

    // Operand magnitudes and the per-cycle trial subtraction
    always_comb begin
        dvd_neg_c = is_signed_i & dividend_i[WIDTH-1];
        dvs_neg_c = is_signed_i & divisor_i[WIDTH-1];
        dvd_mag_c = dvd_neg_c ? WIDTH'(-dividend_i) : dividend_i;
        dvs_mag_c = dvs_neg_c ? WIDTH'(-divisor_i) : divisor_i;
        ovf_c     = is_signed_i && (dividend_i == MIN_VAL) && (divisor_i == '1);
        ge_c      = SW'(rem_q) >= sd_q;
        // Only used when ge_c holds, which implies the upper sd bits are zero
        rem_sub_c = rem_q - sd_q[WIDTH-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            bit_q   <= '0;
            sd_q    <= '0;
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            if (kill_i) begin
                state_q <= IDLE;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            neg_q_q <= dvd_neg_c ^ dvs_neg_c;
                            neg_r_q <= dvd_neg_c;
                            ready_q <= 1'b0;
                            if (divisor_i == '0) begin
                                state_q <= DONE_ERR;
                                valid_q <= 1'b1;
                                error_q <= 1'b1;
                                quot_q  <= '1;
                                remo_q  <= dividend_i;
                            end else if (ovf_c) begin
                                state_q <= DONE;
                                valid_q <= 1'b1;
                                quot_q  <= MIN_VAL;
                                remo_q  <= '0;
                            end else if (dvs_mag_c > dvd_mag_c) begin
                                state_q <= DONE;
                                valid_q <= 1'b1;
                                quot_q  <= '0;
                                remo_q  <= dividend_i;
                            end else begin
                                state_q <= DIVIDE;
                                rem_q   <= dvd_mag_c;
                                q_q     <= '0;
                                sd_q    <= SW'(dvs_mag_c) << (WIDTH - 1);
                                bit_q   <= MIN_VAL;
                            end
                        end
                    end
                    DIVIDE: begin
                        if (ge_c) begin
                            rem_q <= rem_sub_c;
                            q_q   <= q_q | bit_q;
                        end
                        sd_q  <= sd_q >> 1;
                        bit_q <= bit_q >> 1;
                        if (bit_q[0]) begin
                            state_q <= FIXUP;
                        end
                    end
                    FIXUP: begin
                        quot_q  <= neg_q_q ? WIDTH'(-q_q) : q_q;
                        remo_q  <= neg_r_q ? WIDTH'(-rem_q) : rem_q;
                        state_q <= DONE;
                        valid_q <= 1'b1;
                    end
                    DONE, DONE_ERR: begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign ready_o     = ready_q;
    assign valid_o     = valid_q;
    assign error_o     = error_q;
    assign quotient_o  = quot_q;
    assign remainder_o = remo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit at WIDTH=32 and WIDTH=8.
module tb_div_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          lat;
        int          v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic        st32 = 1'b0, k32 = 1'b0, sg32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        rdy32, vld32, err32;
    logic [31:0] qo32, ro32;

    logic        st8 = 1'b0, k8 = 1'b0, sg8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        rdy8, vld8, err8;
    logic [7:0]  qo8, ro8;

    exp_t q32[$];
    exp_t q8[$];
    logic [31:0] last_q = '0, last_r = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_unit #(.WIDTH(32)) u32 (
        .clk_i(clk), .rst_i(rst), .start_i(st32), .kill_i(k32), .is_signed_i(sg32),
        .dividend_i(a32), .divisor_i(b32), .ready_o(rdy32), .valid_o(vld32),
        .error_o(err32), .quotient_o(qo32), .remainder_o(ro32)
    );

    div_unit #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst), .start_i(st8), .kill_i(k8), .is_signed_i(sg8),
        .dividend_i(a8), .divisor_i(b8), .ready_o(rdy8), .valid_o(vld8),
        .error_o(err8), .quotient_o(qo8), .remainder_o(ro8)
    );

    // Reference: plain signed/unsigned arithmetic on wide integers
    function automatic exp_t model(input int n, input bit sgn, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        longint      sa, sb, qq, rr, ma, mb;
        logic [63:0] mask, q64, r64;
        mask = (64'd1 << n) - 64'd1;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[n-1]) sa = sa - (longint'(1) << n);
        if (sgn && b[n-1]) sb = sb - (longint'(1) << n);
        e.e = 1'b0;
        e.v = 0;
        if (b == 64'd0) begin
            q64 = mask; r64 = a; e.e = 1'b1; e.lat = 1;
        end else if (sgn && sa == -(longint'(1) << (n - 1)) && sb == -1) begin
            q64 = a; r64 = 64'd0; e.lat = 1;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            q64 = 64'(qq) & mask;
            r64 = 64'(rr) & mask;
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            e.lat = (mb > ma) ? 1 : n + 2;
        end
        e.q = 32'(q64);
        e.r = 32'(r64);
        return e;
    endfunction

    // Result scoreboard, 32-bit unit
    always @(negedge clk) begin : mon32
        exp_t it;
        if (!rst && vld32) begin
            if (q32.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_valid32 cyc=%0d got valid=1 want none", cyc);
            end else begin
                it = q32.pop_front();
                vectors++;
                if ({err32, qo32, ro32} !== {it.e, it.q, it.r}) begin
                    miscompares++;
                    $display("FAIL result32 acc=%0d got e=%b q=%h r=%h want e=%b q=%h r=%h",
                             it.v, err32, qo32, ro32, it.e, it.q, it.r);
                end
                vectors++;
                if (cyc - it.v !== it.lat) begin
                    miscompares++;
                    $display("FAIL latency32 acc=%0d got %0d want %0d", it.v, cyc - it.v, it.lat);
                end
                last_q = it.q;
                last_r = it.r;
            end
        end
    end

    // Result scoreboard, 8-bit unit
    always @(negedge clk) begin : mon8
        exp_t it;
        if (!rst && vld8) begin
            if (q8.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL unexpected_valid8 cyc=%0d got valid=1 want none", cyc);
            end else begin
                it = q8.pop_front();
                vectors++;
                if ({err8, 24'd0, qo8, 24'd0, ro8} !== {it.e, it.q, it.r}) begin
                    miscompares++;
                    $display("FAIL result8 acc=%0d got e=%b q=%h r=%h want e=%b q=%h r=%h",
                             it.v, err8, qo8, ro8, it.e, it.q[7:0], it.r[7:0]);
                end
                vectors++;
                if (cyc - it.v !== it.lat) begin
                    miscompares++;
                    $display("FAIL latency8 acc=%0d got %0d want %0d", it.v, cyc - it.v, it.lat);
                end
            end
        end
    end

    // Waits for ready, drives one 32-bit op for one cycle and queues its expectation
    task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ee,
                         input int el, output int v);
        exp_t it;
        for (int i = 0; i < 100 && !rdy32; i++) @(negedge clk);
        if (!rdy32) begin
            vectors++; miscompares++;
            $display("FAIL issue_timeout got ready=0 want 1");
        end
        sg32 = sgn; a32 = a; b32 = b; st32 = 1'b1;
        v = cyc;
        it.q = eq; it.r = er; it.e = ee; it.lat = el; it.v = v;
        q32.push_back(it);
        @(negedge clk);
        st32 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        vectors++;
        if (q32.size() != 0 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout got pending=%0d/%0d want 0/0", q32.size(), q8.size());
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({rdy32, vld32, err32, qo32, ro32} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset32 got rdy=%b vld=%b err=%b q=%h r=%h want 1 0 0 0 0",
                     rdy32, vld32, err32, qo32, ro32);
        end
        vectors++;
        if ({rdy8, vld8, err8, qo8, ro8} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL reset8 got rdy=%b vld=%b err=%b q=%h r=%h want 1 0 0 0 0",
                     rdy8, vld8, err8, qo8, ro8);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int v;
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, v);
        drain();
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, v);
        drain();
    endtask

    task automatic test_signed();
        int v;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, v);
        issue(1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          1'b0, 34, v);
        issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 1'b0, 34, v);
        issue(1'b1, 32'h8000_0000, 32'h8000_0000, 32'd1,          32'd0,          1'b0, 34, v);
        drain();
    endtask

    task automatic test_fast_paths();
        int v;
        issue(1'b0, 32'h1234,       32'd0,          32'hFFFF_FFFF, 32'h1234,      1'b1, 1, v);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          1'b0, 1, v);
        issue(1'b1, 32'hFFFF_FFFD, 32'd5,          32'd0,          32'hFFFF_FFFD, 1'b0, 1, v);
        issue(1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b0, 1, v);
        drain();
    endtask

    task automatic test_kill();
        int seen = 0;
        sg32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        repeat (9) @(negedge clk);
        k32 = 1'b1;
        @(negedge clk);
        k32 = 1'b0;
        vectors++;
        if ({rdy32, vld32, qo32, ro32} !== {1'b1, 1'b0, last_q, last_r}) begin
            miscompares++;
            $display("FAIL kill_mid got rdy=%b vld=%b q=%h r=%h want 1 0 %h %h",
                     rdy32, vld32, qo32, ro32, last_q, last_r);
        end
        // Kill together with start in IDLE: nothing is accepted
        a32 = 32'd100; b32 = 32'd7; st32 = 1'b1; k32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0; k32 = 1'b0;
        vectors++;
        if (rdy32 !== 1'b1) begin
            miscompares++;
            $display("FAIL kill_start got rdy=%b want 1", rdy32);
        end
        repeat (40) begin
            @(negedge clk);
            if (vld32 || !rdy32) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL kill_quiet got %0d busy/valid cycles want 0", seen);
        end
    endtask

    task automatic test_ignored_start();
        int v, busy_ok = 0;
        issue(1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 34, v);
        for (int i = 0; i < 20; i++) begin
            if (!rdy32) busy_ok++;
            sg32 = 1'b1; a32 = $urandom; b32 = $urandom; st32 = 1'b1;
            @(negedge clk);
        end
        st32 = 1'b0;
        vectors++;
        if (busy_ok != 20) begin
            miscompares++;
            $display("FAIL ignored_start_busy got %0d busy cycles want 20", busy_ok);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        sg32 = 1'b0; a32 = 32'd5000; b32 = 32'd9; st32 = 1'b1;
        @(negedge clk);
        st32 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({rdy32, vld32, err32, qo32, ro32} !== {1'b1, 1'b0, 1'b0, 32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_mid got rdy=%b vld=%b err=%b q=%h r=%h want 1 0 0 0 0",
                     rdy32, vld32, err32, qo32, ro32);
        end
        @(negedge clk);
        rst = 1'b0;
        last_q = '0;
        last_r = '0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int v1, v2, v3, v4;
        issue(1'b0, 32'd3,    32'd5, 32'd0,          32'd3,    1'b0, 1,  v1);
        issue(1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1,  v2);
        issue(1'b0, 32'd100,  32'd7, 32'd14,         32'd2,    1'b0, 34, v3);
        issue(1'b0, 32'd7,    32'd2, 32'd3,          32'd1,    1'b0, 34, v4);
        drain();
        vectors++;
        if ({v2 - v1, v3 - v2, v4 - v3} !== {32'sd2, 32'sd2, 32'sd35}) begin
            miscompares++;
            $display("FAIL b2b_interval got %0d %0d %0d want 2 2 35", v2 - v1, v3 - v2, v4 - v3);
        end
    endtask

    task automatic rand32(input int n);
        int issued = 0, guard = 0;
        logic [31:0] a, b;
        bit s;
        exp_t it;
        while (issued < n && guard < 60000) begin
            @(negedge clk);
            guard++;
            a = $urandom;
            b = $urandom >> $urandom_range(31, 0);
            s = 1'($urandom_range(1, 0));
            if ($urandom_range(9, 0) == 0) a = 32'h8000_0000;
            case ($urandom_range(7, 0))
                0: b = '0;
                1: b = '1;
                default: ;
            endcase
            sg32 = s; a32 = a; b32 = b;
            if (rdy32) begin
                st32 = 1'b1;
                it = model(32, s, {32'd0, a}, {32'd0, b});
                it.v = cyc;
                q32.push_back(it);
                issued++;
            end else begin
                st32 = 1'($urandom_range(1, 0));
            end
        end
        @(negedge clk);
        st32 = 1'b0;
        vectors++;
        if (issued != n) begin
            miscompares++;
            $display("FAIL rand32_timeout got %0d ops want %0d", issued, n);
        end
    endtask

    task automatic rand8(input int n);
        int issued = 0, guard = 0;
        logic [7:0] a, b;
        bit s;
        exp_t it;
        while (issued < n && guard < 60000) begin
            @(negedge clk);
            guard++;
            a = 8'($urandom);
            b = 8'($urandom) >> $urandom_range(7, 0);
            s = 1'($urandom_range(1, 0));
            if ($urandom_range(9, 0) == 0) a = 8'h80;
            case ($urandom_range(7, 0))
                0: b = '0;
                1: b = '1;
                default: ;
            endcase
            sg8 = s; a8 = a; b8 = b;
            if (rdy8) begin
                st8 = 1'b1;
                it = model(8, s, {56'd0, a}, {56'd0, b});
                it.v = cyc;
                q8.push_back(it);
                issued++;
            end else begin
                st8 = 1'($urandom_range(1, 0));
            end
        end
        @(negedge clk);
        st8 = 1'b0;
        vectors++;
        if (issued != n) begin
            miscompares++;
            $display("FAIL rand8_timeout got %0d ops want %0d", issued, n);
        end
    endtask

    task automatic test_random();
        fork
            rand32(600);
            rand8(3000);
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_fast_paths();
        test_kill();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog got no finish by cyc=%0d want finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
